i2c_reg_ram_arbiter: RTL

Shares one single-port register RAM between two requesters. The first is the I2C register-slave port: pulsed write and read enables, auto-incrementing address, and a read-data word that must always be valid. The second is a local fabric port using a req/ack handshake. The block sequences all RAM accesses and keeps a prefetched read word coherent with the current I2C address. It sits between the I2C register slave and the board's configuration RAM.

---
 rtl/i2c_reg_ram_arbiter.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_ram_arbiter.sv
// i2c_reg_ram_arbiter: sequences every access to one single-port config RAM
// between the I2C register slave (pulsed writes, always-valid prefetched read
// word) and a local fabric port (req/ack).
// Optional build macro: I2C_REG_ARB_WRPROT_EN. When it is defined, pending I2C
// writes at or above WRPROT_BASE are dropped and flagged.
//
// Local handshake: the requester raises locReq with locWr/locAddr/locWrData
// stable and holds them until it sees locAck. locAck is a single-cycle pulse.
// locRdData is valid with that pulse and holds until the next local read.
// The arbiter ignores locReq while locAck is high, so a request that is
// still asserted in the ack cycle is not served a second time.
module i2c_reg_ram_arbiter #(
  parameter int ADDR_SIZE_P = 2,
  parameter int DATA_SIZE_P = 2,
  parameter int RAM_ADDR_W  = 8,
  parameter int WRPROT_BASE = 2**RAM_ADDR_W - 16
) (
  input  logic                       clk,
  input  logic                       sRst,
  input  logic [ADDR_SIZE_P*8-1:0]   i2cAddr,
  input  logic                       i2cWrEn,
  input  logic [DATA_SIZE_P*8-1:0]   i2cWrData,
  input  logic                       i2cRdEn,
  output logic [DATA_SIZE_P*8-1:0]   i2cRdData,
  input  logic                       locReq,
  input  logic                       locWr,
  input  logic [RAM_ADDR_W-1:0]      locAddr,
  input  logic [DATA_SIZE_P*8-1:0]   locWrData,
  output logic                       locAck,
  output logic [DATA_SIZE_P*8-1:0]   locRdData,
  output logic                       ramEn,
  output logic                       ramWe,
  output logic [RAM_ADDR_W-1:0]      ramAddr,
  output logic [DATA_SIZE_P*8-1:0]   ramWrData,
  input  logic [DATA_SIZE_P*8-1:0]   ramRdData,
  input  logic                       clrFlags,
  output logic                       i2cOverrun,
  output logic                       i2cWrBlocked
);

  localparam int IW = ADDR_SIZE_P * 8;
  localparam int DW = DATA_SIZE_P * 8;
  localparam int AW = RAM_ADDR_W;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_I2C_WR     = 3'd1;
  localparam logic [2:0] S_I2C_FETCH  = 3'd2;
  localparam logic [2:0] S_FETCH_WAIT = 3'd3;
  localparam logic [2:0] S_LOC_WR     = 3'd4;
  localparam logic [2:0] S_LOC_RD     = 3'd5;
  localparam logic [2:0] S_LOC_WAIT   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic          wr_pend_q, wr_pend_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [DW-1:0] pend_data_q, pend_data_d;
  logic          wr_en_prev_q, wr_en_prev_d;
  logic          fetch_valid_q, fetch_valid_d;
  logic [AW-1:0] fetch_addr_q, fetch_addr_d;
  logic [DW-1:0] i2c_rd_data_q, i2c_rd_data_d;
  logic [DW-1:0] loc_rd_data_q, loc_rd_data_d;
  logic          loc_ack_q, loc_ack_d;
  logic          ram_en_q, ram_en_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wr_data_q, ram_wr_data_d;
  logic          overrun_q, overrun_d;
  logic          blocked_q, blocked_d;

  logic [AW-1:0] i2c_addr_lo;
  logic          stale;
  logic          wr_prot;
  logic          wr_clr;
  logic          blocked_set;
  logic          overrun_set;

  assign i2c_addr_lo = i2cAddr[AW-1:0];
  assign stale       = !fetch_valid_q || (i2c_addr_lo != fetch_addr_q);

`ifdef I2C_REG_ARB_WRPROT_EN
  localparam logic [AW-1:0] WP_BASE = AW'(WRPROT_BASE);
  assign wr_prot = (pend_addr_q >= WP_BASE);
`else
  // Without protection the blocked flag can never set and reduces to 0.
  assign wr_prot = 1'b0;
`endif

  // The read-done pulse and the address bits above the RAM width carry no function here.
  logic unused_ok;
  assign unused_ok = ^{i2cRdEn, i2cAddr[IW-1:AW], AW'(WRPROT_BASE)};

  // Next-state, RAM command and write-latch logic.
  always_comb begin
    state_d       = state_q;
    wr_pend_d     = wr_pend_q;
    pend_addr_d   = pend_addr_q;
    pend_data_d   = pend_data_q;
    wr_en_prev_d  = i2cWrEn;
    fetch_valid_d = fetch_valid_q;
    fetch_addr_d  = fetch_addr_q;
    i2c_rd_data_d = i2c_rd_data_q;
    loc_rd_data_d = loc_rd_data_q;
    loc_ack_d     = 1'b0;
    ram_en_d      = 1'b0;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    wr_clr        = 1'b0;
    blocked_set   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr_pend_q) begin
          if (wr_prot) begin
            wr_clr      = 1'b1;
            blocked_set = 1'b1;
          end else begin
            state_d       = S_I2C_WR;
            ram_en_d      = 1'b1;
            ram_we_d      = 1'b1;
            ram_addr_d    = pend_addr_q;
            ram_wr_data_d = pend_data_q;
          end
        end else if (stale) begin
          state_d       = S_I2C_FETCH;
          ram_en_d      = 1'b1;
          ram_addr_d    = i2c_addr_lo;
          fetch_addr_d  = i2c_addr_lo;
          fetch_valid_d = 1'b0;
        end else if (locReq && !loc_ack_q && !i2cWrEn) begin
          // A write being captured this cycle outranks a local request that
          // arrives with it; it becomes wrPend and is granted next cycle.
          state_d       = locWr ? S_LOC_WR : S_LOC_RD;
          ram_en_d      = 1'b1;
          ram_we_d      = locWr;
          ram_addr_d    = locAddr;
          ram_wr_data_d = locWrData;
        end
      end
      S_I2C_WR: begin
        // A capture during the grant cycle replaced the slot after its old
        // contents were issued, so that newer write must stay pending.
        wr_clr = !wr_en_prev_q;
        if (ram_addr_q == fetch_addr_q) fetch_valid_d = 1'b0;
        state_d = S_IDLE;
      end
      S_I2C_FETCH: begin
        state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        i2c_rd_data_d = ramRdData;
        fetch_valid_d = !((wr_pend_q && (pend_addr_q == fetch_addr_q)) ||
                          (i2cWrEn && (i2c_addr_lo == fetch_addr_q)));
        state_d       = S_IDLE;
      end
      S_LOC_WR: begin
        if (ram_addr_q == fetch_addr_q) fetch_valid_d = 1'b0;
        loc_ack_d = 1'b1;
        state_d   = S_IDLE;
      end
      S_LOC_RD: begin
        state_d = S_LOC_WAIT;
      end
      S_LOC_WAIT: begin
        loc_rd_data_d = ramRdData;
        loc_ack_d     = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Capture wins over any clear of the pending slot in the same cycle.
    if (i2cWrEn) begin
      pend_addr_d = i2c_addr_lo;
      pend_data_d = i2cWrData;
      wr_pend_d   = 1'b1;
    end else if (wr_clr) begin
      wr_pend_d = 1'b0;
    end

    overrun_set = i2cWrEn && wr_pend_q;
    overrun_d   = overrun_set ? 1'b1 : (clrFlags ? 1'b0 : overrun_q);
    blocked_d   = blocked_set ? 1'b1 : (clrFlags ? 1'b0 : blocked_q);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (sRst) begin
      state_q       <= S_IDLE;
      wr_pend_q     <= 1'b0;
      pend_addr_q   <= '0;
      pend_data_q   <= '0;
      wr_en_prev_q  <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_addr_q  <= '0;
      i2c_rd_data_q <= '0;
      loc_rd_data_q <= '0;
      loc_ack_q     <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wr_data_q <= '0;
      overrun_q     <= 1'b0;
      blocked_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_pend_q     <= wr_pend_d;
      pend_addr_q   <= pend_addr_d;
      pend_data_q   <= pend_data_d;
      wr_en_prev_q  <= wr_en_prev_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_addr_q  <= fetch_addr_d;
      i2c_rd_data_q <= i2c_rd_data_d;
      loc_rd_data_q <= loc_rd_data_d;
      loc_ack_q     <= loc_ack_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      overrun_q     <= overrun_d;
      blocked_q     <= blocked_d;
    end
  end

  assign i2cRdData    = i2c_rd_data_q;
  assign locRdData    = loc_rd_data_q;
  assign locAck       = loc_ack_q;
  assign ramEn        = ram_en_q;
  assign ramWe        = ram_we_q;
  assign ramAddr      = ram_addr_q;
  assign ramWrData    = ram_wr_data_q;
  assign i2cOverrun   = overrun_q;
  assign i2cWrBlocked = blocked_q;

endmodule
